// File: rtl/adam_jtag_mst.sv
// JTAG initiator: valid/ready commands become TCK/TMS/TDI sequences, captured TDO returns as a response.
// Optional macro ADAM_JTAG_MST_TDO_SYNC_EN adds a two-flop synchronizer on jtag_tdo_i (needs HALF_PERIOD >= 3).
module adam_jtag_mst #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned MAX_LEN     = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [MAX_LEN-1:0]       cmd_tms_i,
  input  logic [MAX_LEN-1:0]       cmd_tdi_i,
  input  logic [$clog2(MAX_LEN):0] cmd_len_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  output logic [MAX_LEN-1:0]       rsp_tdo_o,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     jtag_tck_o,
  output logic                     jtag_tms_o,
  output logic                     jtag_tdi_o,
  input  logic                     jtag_tdo_i
);

  localparam int unsigned LW = $clog2(MAX_LEN) + 1;
  localparam int unsigned IW = $clog2(MAX_LEN);
  localparam int unsigned PW = $clog2(HALF_PERIOD);
  localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD - 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic [LW-1:0]      idx_q, idx_d, len_q, len_d;
  logic [LW-1:0]      len_clamp, idx_nxt;
  logic [MAX_LEN-1:0] tms_sr_q, tms_sr_d, tdi_sr_q, tdi_sr_d, tdo_q, tdo_d;
  logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic               ready_q, ready_d, valid_q, valid_d;
  logic               tdo_s;

`ifdef ADAM_JTAG_MST_TDO_SYNC_EN
  logic [1:0] tdo_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tdo_sync_q <= 2'b00;
    else         tdo_sync_q <= {tdo_sync_q[0], jtag_tdo_i};
  end

  assign tdo_s = tdo_sync_q[1];

  if (HALF_PERIOD < 3) begin : g_hp_check
    $error("adam_jtag_mst: HALF_PERIOD must be >= 3 with the TDO synchronizer");
  end
`else
  assign tdo_s = jtag_tdo_i;

  if (HALF_PERIOD < 2) begin : g_hp_check
    $error("adam_jtag_mst: HALF_PERIOD must be >= 2");
  end
`endif

  assign len_clamp = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;
  assign idx_nxt   = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    len_d    = len_q;
    tms_sr_d = tms_sr_q;
    tdi_sr_d = tdi_sr_q;
    tdo_d    = tdo_q;
    tck_d    = tck_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid_i && ready_q) begin
          ready_d  = 1'b0;
          tms_sr_d = cmd_tms_i;
          tdi_sr_d = cmd_tdi_i;
          len_d    = len_clamp;
          tdo_d    = '0;
          idx_d    = '0;
          phase_d  = '0;
          // len=0 skips straight to the response and leaves TMS/TDI untouched
          if (len_clamp == '0) begin
            state_d = RESP;
            valid_d = 1'b1;
          end else begin
            state_d = LOW;
            tms_d   = cmd_tms_i[0];
            tdi_d   = cmd_tdi_i[0];
          end
        end
      end
      LOW: begin
        phase_d = phase_q + 1'b1;
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          state_d = HIGH;
          tck_d   = 1'b1;
        end
      end
      HIGH: begin
        phase_d = phase_q + 1'b1;
        if (phase_q == PH_LAST) begin
          // sample on the edge that drops TCK, before the target moves TDO
          phase_d = '0;
          tck_d   = 1'b0;
          tdo_d[idx_q[IW-1:0]] = tdo_s;
          if (idx_nxt < len_q) begin
            state_d = LOW;
            idx_d   = idx_nxt;
            tms_d   = tms_sr_q[idx_nxt[IW-1:0]];
            tdi_d   = tdi_sr_q[idx_nxt[IW-1:0]];
          end else begin
            state_d = RESP;
            valid_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      tms_sr_q <= '0;
      tdi_sr_q <= '0;
      tdo_q    <= '0;
      tck_q    <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      tms_sr_q <= tms_sr_d;
      tdi_sr_q <= tdi_sr_d;
      tdo_q    <= tdo_d;
      tck_q    <= tck_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_tdo_o   = tdo_q;
  assign jtag_tck_o  = tck_q;
  assign jtag_tms_o  = tms_q;
  assign jtag_tdi_o  = tdi_q;

endmodule

// File: tb/tb_adam_jtag_mst.sv
// Bench for adam_jtag_mst: a cycle-timing model checks every output each cycle, plus literal spot checks.
module tb_adam_jtag_mst;
`ifdef ADAM_JTAG_MST_TDO_SYNC_EN
  localparam int H = 3;
  localparam int D = 3;
`else
  localparam int H = 4;
  localparam int D = 1;
`endif
  localparam int ML = 32;
  localparam int HM = 16383;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [ML-1:0] cmd_tms, cmd_tdi;
  logic [5:0]    cmd_len;
  logic          cmd_valid, cmd_ready;
  logic [ML-1:0] rsp_tdo;
  logic          rsp_valid, rsp_ready;
  logic          tck, tms, tdi;
  logic          tdo = 1'b0;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  int   tgt_mode = 0;
  logic tgt_const = 1'b0;
  int   rises = 0;
  bit   hist [0:HM];

  adam_jtag_mst #(.HALF_PERIOD(H), .MAX_LEN(ML)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_tms_i(cmd_tms), .cmd_tdi_i(cmd_tdi), .cmd_len_i(cmd_len),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .rsp_tdo_o(rsp_tdo), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi), .jtag_tdo_i(tdo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Target model: mode 0 constant, 1 TDI loopback delayed one TCK, 2 toggle one cycle after each TCK fall
  initial begin
    logic prev, reg1, pend;
    prev = 1'b0; reg1 = 1'b0; pend = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tck && !prev) begin
        rises++;
        reg1 = tdi;
      end
      case (tgt_mode)
        1: if (!tck && prev) tdo = reg1;
        2: begin
          if (pend) begin tdo = ~tdo; pend = 1'b0; end
          if (!tck && prev) pend = 1'b1;
        end
        default: begin tdo = tgt_const; pend = 1'b0; end
      endcase
      prev = tck;
      hist[cyc & HM] = tdo;
    end
  end

  // Timing model: everything derives from the accept cycle e0 and the clamped length
  initial begin
    bit armed, active;
    int e0, mlen, t, run;
    logic [ML-1:0] mtms, mtdi, e_tdo;
    logic last_tms, last_tdi, e_tck, e_tms, e_tdi, e_rdy, e_vld, in_rsp;
    armed = 0; active = 0; e0 = 0; mlen = 0; mtms = '0; mtdi = '0;
    last_tms = 1'b1; last_tdi = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        chk("rst_tck", tck, 0); chk("rst_tms", tms, 1); chk("rst_tdi", tdi, 0);
        chk("rst_cmd_ready", cmd_ready, 0); chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_tdo", rsp_tdo, 0);
        armed = 0; active = 0; last_tms = 1'b1; last_tdi = 1'b0;
        continue;
      end
      e_tck = 0; e_tms = last_tms; e_tdi = last_tdi; e_rdy = armed; e_vld = 0;
      in_rsp = 0; e_tdo = '0; t = 0; run = 0;
      if (active) begin
        t = cyc - e0;
        run = 2 * H * mlen;
        e_rdy = 0;
        if (t < run) begin
          e_tck = (t % (2 * H)) >= H;
          e_tms = mtms[t / (2 * H)];
          e_tdi = mtdi[t / (2 * H)];
        end else begin
          in_rsp = 1; e_vld = 1;
          if (mlen > 0) begin e_tms = mtms[mlen-1]; e_tdi = mtdi[mlen-1]; end
          for (int i = 0; i < mlen; i++) e_tdo[i] = hist[(e0 + 2 * H * (i + 1) - D) & HM];
        end
      end
      chk("tck", tck, e_tck); chk("tms", tms, e_tms); chk("tdi", tdi, e_tdi);
      chk("cmd_ready", cmd_ready, e_rdy); chk("rsp_valid", rsp_valid, e_vld);
      if (in_rsp) chk("rsp_tdo", rsp_tdo, e_tdo);
      if (!active) begin
        if (!armed) armed = 1;
        else if (cmd_valid) begin
          active = 1; armed = 0; e0 = cyc + 1;
          mlen = (cmd_len > ML) ? ML : int'(cmd_len);
          mtms = cmd_tms; mtdi = cmd_tdi;
        end
      end else if (in_rsp && rsp_ready) begin
        active = 0; armed = 1;
        if (mlen > 0) begin last_tms = mtms[mlen-1]; last_tdi = mtdi[mlen-1]; end
      end
    end
  end

  task automatic send(input int len, input logic [ML-1:0] t_ms, input logic [ML-1:0] t_di,
                      output int e0, output int r0);
    int w;
    cmd_len = 6'(len); cmd_tms = t_ms; cmd_tdi = t_di; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 200) begin @(posedge clk); #2; w++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    r0 = rises;
    @(posedge clk); #2;
    e0 = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int rc);
    int w;
    w = 0;
    while (!rsp_valid && w < 2000) begin @(posedge clk); #2; w++; end
    chk("rsp_valid_wait", rsp_valid, 1);
    rc = cyc;
  endtask

  task automatic run_cmd(input string name, input int len, input logic [ML-1:0] t_ms,
                         input logic [ML-1:0] t_di, input int exp_pulses, input logic [ML-1:0] exp_tdo);
    int e0, r0, rc;
    send(len, t_ms, t_di, e0, r0);
    wait_rsp(rc);
    chk({name, "_latency"}, rc - e0, 2 * H * exp_pulses);
    chk({name, "_tdo"}, rsp_tdo, exp_tdo);
    @(posedge clk); #2;
    chk({name, "_pulses"}, rises - r0, exp_pulses);
  endtask

  initial begin
    int e0, r0, rc;
    rst_ni = 1'b0; cmd_valid = 1'b1; cmd_len = 6'd1; cmd_tms = '0; cmd_tdi = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_hold_ready", cmd_ready, 0);
    chk("rst_hold_tms", tms, 1);
    rst_ni = 1'b1;
    @(posedge clk); #2;
    chk("ready_after_release", cmd_ready, 1);
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // TAP reset then IR-style shift with loopback target
    tgt_mode = 1;
    run_cmd("tap_reset", 5, 32'h1F, 32'h0, 5, 32'h0);
    run_cmd("ir_shift", 12, 32'hC03, 32'h2A5, 12, 32'h54A);
    chk("ir_shift_96", 2 * 4 * 12, 96);

    // length edges
    run_cmd("len0", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0);
    tgt_mode = 0; tgt_const = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    run_cmd("len40", 40, 32'h0, 32'h1234_5678, 32, 32'hFFFF_FFFF);
    run_cmd("len32", 32, 32'hAAAA_5555, 32'h0F0F_F0F0, 32, 32'hFFFF_FFFF);

    // response backpressure with a command waiting
    rsp_ready = 1'b0;
    send(3, 32'h5, 32'h3, e0, r0);
    wait_rsp(rc);
    chk("bp_latency", rc - e0, 2 * H * 3);
    cmd_len = 6'd2; cmd_tms = 32'h2; cmd_tdi = 32'h1; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      chk("bp_valid", rsp_valid, 1); chk("bp_tdo", rsp_tdo, 32'h7);
      chk("bp_ready", cmd_ready, 0); chk("bp_tck", tck, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_hs_valid", rsp_valid, 0);
    chk("bp_hs_ready", cmd_ready, 1);
    @(posedge clk); #2;
    chk("bp_accept_next_edge", cmd_ready, 0);
    e0 = cyc;
    cmd_valid = 1'b0;
    wait_rsp(rc);
    chk("bp_next_latency", rc - e0, 2 * H * 2);
    chk("bp_next_tdo", rsp_tdo, 32'h3);
    @(posedge clk); #2;

    // reset during bit 3 of an 8-bit command
    send(8, 32'hFF, 32'hAA, e0, r0);
    repeat (2 * H * 3 + H) @(posedge clk);
    #2;
    chk("mid_tck_high", tck, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("mid_tck_async", tck, 0);
    chk("mid_tms_async", tms, 1);
    chk("mid_valid_async", rsp_valid, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_ni = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_no_rsp", rsp_valid, 0);
    run_cmd("after_rst", 1, 32'h0, 32'h1, 1, 32'h1);

    // TDO toggling one cycle after each TCK fall
    tgt_const = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    tgt_mode = 2;
    run_cmd("toggle", 8, 32'h0, 32'h0F, 8, 32'hAA);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adam_jtag_mst.md
# adam_jtag_mst

JTAG initiator that turns a valid/ready command stream into TCK/TMS/TDI bit sequences and returns captured TDO bits on a valid/ready response stream. It drives the four-wire JTAG interface that the ADAM debug module's TAP receives. Typical uses are bench-side debug access and a host bridge feeding the TAP from an on-chip or FPGA-side controller.

## Interface
- `HALF_PERIOD`, default 4: TCK half-period in `clk_i` cycles, range 2..255.
- `MAX_LEN`, default 32: maximum bits per command; sets the width of the TMS, TDI and TDO vectors.
- `clk_i` input 1: system clock.
- `rst_ni` input 1: reset, asynchronous assert, active-low (the already-decided reset of this block).
- `cmd_tms_i` input MAX_LEN: TMS bit per TCK cycle, LSB first.
- `cmd_tdi_i` input MAX_LEN: TDI bit per TCK cycle, LSB first.
- `cmd_len_i` input $clog2(MAX_LEN)+1: number of TCK cycles; values above MAX_LEN are clamped to MAX_LEN.
- `cmd_valid_i` input 1 / `cmd_ready_o` output 1: command handshake.
- `rsp_tdo_o` output MAX_LEN: captured TDO; bit i is the value from TCK cycle i; bits at index ≥ len are 0.
- `rsp_valid_o` output 1 / `rsp_ready_i` input 1: response handshake.
- `jtag_tck_o`, `jtag_tms_o`, `jtag_tdi_o` output 1: JTAG pins.
- `jtag_tdo_i` input 1: JTAG TDO from the target.

## Operation
- FSM states: IDLE, LOW, HIGH, RESP.
  - IDLE: `cmd_ready_o`=1. On `cmd_valid_i && cmd_ready_o`:
    - latch TMS, TDI and clamped length;
    - clear the TDO shift register;
    - go to LOW, or go directly to RESP when len=0.
  - LOW: `jtag_tck_o`=0. TMS/TDI show bit i, updated on entry. Hold for HALF_PERIOD cycles, then go to HIGH.
  - HIGH: `jtag_tck_o`=1 for HALF_PERIOD cycles. On the final HIGH cycle's edge, sample TDO into bit i.
    - If i+1 < len: go to LOW with i+1.
    - Else: go to RESP.
  - RESP: `rsp_valid_o`=1 and `rsp_tdo_o` stable. On `rsp_ready_i`, go to IDLE.
- All JTAG outputs are registered.
- `jtag_tck_o` is 0 in IDLE and RESP.
- TMS and TDI hold their last driven value after the final bit, until the next command.
- Changing TMS/TDI only in LOW gives setup and hold of HALF_PERIOD cycles around TCK rise.
- TDO is sampled just before TCK falls. The target updates TDO on TCK fall, so the sample is valid.
- Counters:
  - phase counter is $clog2(HALF_PERIOD) bits and wraps at HALF_PERIOD-1;
  - bit index is $clog2(MAX_LEN)+1 bits and never wraps, because the length is clamped.

## Timing
- Reset values: `jtag_tck_o`=0, `jtag_tms_o`=1, `jtag_tdi_o`=0, `cmd_ready_o`=0, `rsp_valid_o`=0, `rsp_tdo_o`=0.
- `cmd_ready_o` rises on the first clock edge after `rst_ni` deasserts.
- Accept edge E0:
  - TMS/TDI bit 0 are valid from E0;
  - TCK rises at E0+H and falls at E0+2H (H = HALF_PERIOD);
  - bit i occupies E0+2H·i .. E0+2H·(i+1).
- `rsp_valid_o` rises at E0+2H·len. For len=0 it rises at E0 and no TCK pulse is produced.
- A response handshake at edge R gives `cmd_ready_o`=1 from R. The next command is accepted at R+1 at the earliest (one-cycle bubble).
- No command is accepted while the FSM is in LOW, HIGH or RESP.
- `rsp_ready_i` held high: RESP lasts exactly one cycle.
- Reset mid-operation: outputs return to their reset values immediately (asynchronous). The command is dropped and no response is produced.

## Configuration
- `ADAM_JTAG_MST_TDO_SYNC_EN`:
  - Defined: `jtag_tdo_i` passes through a two-flop synchronizer before sampling. The sample point is unchanged, so the captured value reflects TDO two cycles before TCK fall. An elaboration-time check requires HALF_PERIOD ≥ 3.
  - Undefined: `jtag_tdo_i` is sampled directly, and HALF_PERIOD ≥ 2 is allowed.

## Test plan
- **Reset:** hold `rst_ni`=0 with `cmd_valid_i`=1 → TCK=0, TMS=1, TDI=0, `cmd_ready_o`=0. Release `rst_ni` → `cmd_ready_o`=1 one edge later.
- **TAP reset plus IR shift:** H=4, len=5, TMS=5'b11111, then len=12, TMS=12'b110000000011, TDI=0x2A5, target TDO loopback of TDI delayed one TCK → 5 and 12 TCK pulses of 8 cycles each, `rsp_tdo_o` equals TDI shifted by one, `rsp_valid_o` at E0+96 for the second command.
- **Length edges:**
  - len=0 → `rsp_valid_o` at E0, `rsp_tdo_o`=0, no TCK edge;
  - len=40 with MAX_LEN=32 → exactly 32 pulses;
  - len=32 with TDO tied high → `rsp_tdo_o`=0xFFFFFFFF.
- **Response backpressure:** `rsp_ready_i`=0 for 20 cycles → `rsp_valid_o` and `rsp_tdo_o` stable, `cmd_ready_o`=0, TCK=0. Release → next command accepted one edge after the handshake.
- **Reset mid-operation:** assert `rst_ni`=0 at bit 3 of len=8 → TCK=0 in the same cycle, no response. After release, a fresh len=1 command completes normally.
- **Synchronizer:** with `ADAM_JTAG_MST_TDO_SYNC_EN` and H=3, TDO toggling one cycle after each TCK fall → captured bits match the pattern.
